// File: rtl/button_debounce_mmio.sv
// rtl/button_debounce_mmio.sv - synchronized, debounced push buttons with W1C press events on a two-word MMIO window
module button_debounce_mmio #(
   parameter int          NUM_BTN         = 5,
   parameter int          DEBOUNCE_CYCLES = 250000,
   parameter logic [31:0] BASE_ADDR       = 32'd1000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic [31:0]        addr,
   input  logic               wren,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               hit,
   output logic [NUM_BTN-1:0] btn_level,
   output logic               btn_event
);
   localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0]    EVT_ADDR = BASE_ADDR + 32'd1;

   logic [NUM_BTN-1:0] s1;
   logic [NUM_BTN-1:0] s2;
   logic [NUM_BTN-1:0] level;
   logic [NUM_BTN-1:0] level_next;
   logic [NUM_BTN-1:0] pend;
   logic [NUM_BTN-1:0] pend_next;
   logic [NUM_BTN-1:0] clr;
   logic [CW-1:0]      cnt      [NUM_BTN];
   logic [CW-1:0]      cnt_next [NUM_BTN];
   logic               sel_level;
   logic               sel_pend;

   // A counter only runs while the synchronized input disagrees with the accepted level
   always_comb begin
      level_next = level;
      for (int i = 0; i < NUM_BTN; i++) begin
         cnt_next[i] = '0;
         if (s2[i] != level[i]) begin
            if (cnt[i] == CNT_MAX) begin
               level_next[i] = s2[i];
            end else begin
               cnt_next[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   // Rising-level set is OR'd in after the clear so a coincident press is never lost
   always_comb begin
      clr       = (wren && (addr == EVT_ADDR)) ? wdata[NUM_BTN-1:0] : '0;
      pend_next = (pend & ~clr) | (level_next & ~level);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1    <= '0;
         s2    <= '0;
         level <= '0;
         pend  <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1    <= btn_raw;
         s2    <= s1;
         level <= level_next;
         pend  <= pend_next;
         for (int i = 0; i < NUM_BTN; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

   always_comb begin
      sel_level = (addr == BASE_ADDR);
      sel_pend  = (addr == EVT_ADDR);
      hit       = sel_level | sel_pend;
      rdata     = 32'd0;
      if (sel_level) begin
         rdata = 32'(level);
      end else if (sel_pend) begin
         rdata = 32'(pend);
      end
   end

   assign btn_level = level;
   assign btn_event = |pend;

endmodule

// File: tb/tb_button_debounce_mmio.sv
// tb/tb_button_debounce_mmio.sv - scoreboard bench for button_debounce_mmio against a sample-history model
`timescale 1ns/1ps
module tb_button_debounce_mmio;
   localparam int          NB = 5;
   localparam int          DC = 4;
   localparam logic [31:0] BA = 32'd1000;

   logic           clock   = 1'b0;
   logic           reset   = 1'b1;
   logic [NB-1:0]  btn_raw = '0;
   logic [31:0]    addr    = '0;
   logic           wren    = 1'b0;
   logic [31:0]    wdata   = '0;
   logic [31:0]    rdata;
   logic           hit;
   logic [NB-1:0]  btn_level;
   logic           btn_event;

   always #5 clock = ~clock;

   button_debounce_mmio #(
      .NUM_BTN        (NB),
      .DEBOUNCE_CYCLES(DC),
      .BASE_ADDR      (BA)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .btn_raw  (btn_raw),
      .addr     (addr),
      .wren     (wren),
      .wdata    (wdata),
      .rdata    (rdata),
      .hit      (hit),
      .btn_level(btn_level),
      .btn_event(btn_event)
   );

   // Model: a level flips once the DC most recent synchronizer outputs all disagree with it;
   // the synchronizer output used at edge k is the raw value sampled at edge k-2.
   logic [NB-1:0] hist [$];
   logic [NB-1:0] m_level = '0;
   logic [NB-1:0] m_pend  = '0;

   function automatic logic [NB-1:0] smp(input int j);
      if (j >= 0) return hist[j];
      return '0;
   endfunction

   always @(posedge clock or posedge reset) begin
      logic [NB-1:0] nl;
      logic [NB-1:0] clrm;
      logic [NB-1:0] s;
      logic          all_diff;
      int            k;
      if (reset) begin
         hist.delete();
         m_level <= '0;
         m_pend  <= '0;
      end else begin
         nl = m_level;
         k  = hist.size();
         for (int i = 0; i < NB; i++) begin
            all_diff = 1'b1;
            for (int d = 2; d <= DC + 1; d++) begin
               s = smp(k - d);
               if (s[i] == m_level[i]) all_diff = 1'b0;
            end
            if (all_diff) nl[i] = ~m_level[i];
         end
         clrm = (wren && addr == BA + 32'd1) ? wdata[NB-1:0] : '0;
         m_pend  <= (m_pend & ~clrm) | (nl & ~m_level);
         m_level <= nl;
         hist.push_back(btn_raw);
      end
   end

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      if (a == BA)         return 32'(m_level);
      if (a == BA + 32'd1) return 32'(m_pend);
      return 32'd0;
   endfunction

   typedef struct {
      logic [31:0] a;
      logic [31:0] rd;
      logic        h;
      logic [NB-1:0] lv;
      logic        ev;
      string       name;
   } exp_t;

   exp_t sb [$];
   event req_ev;
   int   passed = 0;
   int   total  = 0;

   task automatic push_chk(input logic [31:0] a, input logic [31:0] rd_exp, input string nm);
      exp_t e;
      e.a    = a;
      e.rd   = rd_exp;
      e.h    = (a == BA) || (a == BA + 32'd1);
      e.lv   = m_level;
      e.ev   = |m_pend;
      e.name = nm;
      sb.push_back(e);
      -> req_ev;
   endtask

   task automatic rd(input logic [31:0] a, input string nm);
      addr = a;
      #1;
      push_chk(a, model_rd(a), nm);
      #1;
   endtask

   task automatic rd_k(input logic [31:0] a, input logic [31:0] k, input string nm);
      addr = a;
      #1;
      push_chk(a, k, nm);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wren  = 1'b1;
      @(negedge clock);
      wren  = 1'b0;
      wdata = '0;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(req_ev);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (rdata === e.rd && hit === e.h && btn_level === e.lv && btn_event === e.ev) begin
               passed++;
            end else begin
               $display("FAIL %s: addr=%0d rdata=%h exp %h hit=%b exp %b level=%h exp %h event=%b exp %b",
                        e.name, e.a, rdata, e.rd, hit, e.h, btn_level, e.lv, btn_event, e.ev);
            end
         end
      end
   end

   initial begin
      int hold;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      rd_k(BA, 0, "idle_lvl");
      rd_k(BA + 1, 0, "idle_pend");
      @(negedge clock);
      rd_k(BA - 1, 0, "idle_999");
      rd_k(BA + 2, 0, "idle_1002");

      @(negedge clock);
      btn_raw = 5'h04;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clock);
         rd_k(BA, (k >= 5) ? 32'h4 : 32'h0, "press_lat");
      end
      rd_k(BA + 1, 32'h4, "press_pend");
      for (int r = 0; r < 3; r++) begin
         @(negedge clock);
         rd_k(BA + 1, 32'h4, "pend_nondestr");
      end

      @(negedge clock);
      btn_raw = 5'h00;
      repeat (8) @(negedge clock);
      rd_k(BA, 32'h0, "release_lvl");
      rd_k(BA + 1, 32'h4, "release_pend");

      @(negedge clock);
      btn_raw = 5'h01;
      repeat (3) @(negedge clock);
      btn_raw = 5'h00;
      repeat (8) @(negedge clock);
      rd_k(BA, 32'h0, "glitch_lvl");
      rd_k(BA + 1, 32'h4, "glitch_pend");

      @(negedge clock);
      btn_raw = 5'h01;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clock);
         rd_k(BA, (k >= 5) ? 32'h1 : 32'h0, "hold_lat");
      end
      repeat (4) @(negedge clock);
      btn_raw = 5'h00;
      repeat (8) @(negedge clock);
      rd_k(BA + 1, 32'h5, "pend_two");

      @(negedge clock);
      wr(BA + 1, 32'h1);
      rd_k(BA + 1, 32'h4, "w1c_one");
      @(negedge clock);
      btn_raw = 5'h02;
      repeat (8) @(negedge clock);
      wr(BA, 32'h1F);
      rd_k(BA, 32'h2, "wr_level_ign");
      rd_k(BA + 1, 32'h6, "pend_after_ign");
      @(negedge clock);
      wr(BA + 1, 32'hFFFF_FFFF);
      rd_k(BA + 1, 32'h0, "w1c_all");
      btn_raw = 5'h00;
      repeat (8) @(negedge clock);

      btn_raw = 5'h08;
      repeat (5) @(negedge clock);
      addr  = BA + 1;
      wdata = 32'h8;
      wren  = 1'b1;
      @(negedge clock);
      wren  = 1'b0;
      wdata = '0;
      rd_k(BA, 32'h8, "simul_lvl");
      rd_k(BA + 1, 32'h8, "simul_pend");
      @(negedge clock);
      btn_raw = 5'h00;
      repeat (8) @(negedge clock);
      wr(BA + 1, 32'hFFFF_FFFF);

      btn_raw = 5'h03;
      repeat (8) @(negedge clock);
      rd_k(BA + 1, 32'h3, "pre_rst_pend");
      @(negedge clock);
      btn_raw = 5'h13;
      repeat (4) @(negedge clock);
      #1;
      reset = 1'b1;
      rd_k(BA, 32'h0, "rst_lvl");
      rd_k(BA + 1, 32'h0, "rst_pend");
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clock);
         rd_k(BA, (k >= 5) ? 32'h13 : 32'h0, "post_rst_lat");
      end
      rd_k(BA + 1, 32'h13, "post_rst_pend");

      hold = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clock);
         if (hold == 0) begin
            btn_raw = NB'($urandom);
            hold    = $urandom_range(1, 12);
         end else begin
            hold--;
         end
         wren  = ($urandom_range(0, 9) < 2);
         wdata = $urandom;
         rd(BA - 2 + 32'($urandom_range(0, 5)), "rand");
      end
      @(negedge clock);
      wren = 1'b0;
      rd(BA, "final_lvl");
      rd(BA + 1, "final_pend");

      #1;
      total++;
      if (sb.size() == 0) passed++;
      else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/button_debounce_mmio.md
# button_debounce_mmio

Memory-mapped push-button input stage feeding the processor's data-memory read path. It synchronizes and debounces up to `NUM_BTN` raw board buttons, latches press events in a write-1-to-clear register, and presents both through a two-word window at `BASE_ADDR` that the top level muxes onto `q_dmem` when `hit` is asserted. It replaces the direct, unfiltered button-to-load connection at address 1000.

## Interface
- `NUM_BTN`, 5, number of buttons; 1..32
- `DEBOUNCE_CYCLES`, 250000, consecutive stable cycles required to accept a change; must be at least 2; counter width is `$clog2(DEBOUNCE_CYCLES)`
- `BASE_ADDR`, 1000, word address of the level register; the event register is at `BASE_ADDR+1`

- `clock` in 1: single clock; all state updates on the rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `btn_raw` in `NUM_BTN`: asynchronous raw button pins, 1 = pressed
- `addr` in 32: processor `address_dmem`
- `wren` in 1: processor data-memory write enable
- `wdata` in 32: processor store data
- `rdata` out 32: read data, combinational from `addr`
- `hit` out 1: combinational; 1 when `addr` is `BASE_ADDR` or `BASE_ADDR+1`
- `btn_level` out `NUM_BTN`: debounced button levels
- `btn_event` out 1: OR of all pending event bits

## Operation
- Synchronizer: two flops per button (`s1`, `s2`); `s1` samples `btn_raw`, and `s2` samples `s1`.
- Debounce, per button, with an independent counter `cnt[i]`:
  - If `s2[i] == level[i]`: `cnt[i]` is set to 0.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `level[i]` is set to `s2[i]` and `cnt[i]` to 0.
  - Else: `cnt[i]` increments.
  - Any single-cycle return to the old level restarts the count, which rejects glitches shorter than `DEBOUNCE_CYCLES`.
- Event register `pend[NUM_BTN-1:0]`:
  - Bit i is set on the edge where `level[i]` goes 0→1.
  - Bit i is cleared on an edge with `wren=1`, `addr==BASE_ADDR+1` and `wdata[i]=1`.
  - If set and clear hit the same bit on the same edge, set wins.
  - Falling levels never touch `pend`.
- Read map, zero-extended to 32 bits:
  - `BASE_ADDR` returns `level`.
  - `BASE_ADDR+1` returns `pend`.
  - Any other address returns 0 and `hit=0`.
- Reads are non-destructive. A pipelined load may sample `rdata` in several cycles without side effects.
- Writes to `BASE_ADDR` are ignored. `wdata` bits at index `NUM_BTN` and above are ignored.
- `btn_level = level`; `btn_event = |pend`.

## Timing
- Reset values: `s1`, `s2`, `level`, `cnt` and `pend` are all 0. Hence `btn_level=0`, `btn_event=0`, and `rdata=0` at both addresses.
- Reset asserted mid-count or with events pending clears everything immediately, with no clock required.
- Latency: `btn_raw` rises before edge E0 and then holds. The edges proceed as follows:
  - `s2` is high after edge E1.
  - `level` rises on edge E(1+DEBOUNCE_CYCLES).
  - `pend` sets on that same edge.
- Release follows the same latency, with no `pend` change.
- `rdata` and `hit` follow `addr` and the register state combinationally, so a load sees state as of the previous edge.
- A W1C write takes effect at the edge where `wren` is sampled; a read in the next cycle shows the cleared bit.
- Counter never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap.

## Test plan
Use `DEBOUNCE_CYCLES=4`, `NUM_BTN=5`, `BASE_ADDR=1000`.
- Reset then idle: with `addr=1000` and `addr=1001`, `rdata=0` and `hit=1`; with `addr=999` and `addr=1002`, `hit=0` and `rdata=0`; `btn_event=0`.
- Clean press of btn 2, raw rising before E0 and held: `level[2]` rises on E5; after E5, `rdata@1000=0x4`, `rdata@1001=0x4`, and `btn_event=1`. Reading 1001 repeatedly keeps the value 0x4.
- Glitch: btn 0 high for 3 cycles, then low: `level` stays 0 and `pend` stays 0. Then btn 0 held 10 cycles: `level[0]` rises exactly 5 edges after the raw rise.
- W1C: `pend=0x5` with a store of `wdata=0x1` to 1001 gives `pend=0x4` on the next read. A store of `0xFFFFFFFF` to 1001 gives 0 and `btn_event=0`. A store of 0x1F to 1000 leaves `level` unchanged.
- Simultaneous set and clear: a W1C of bit 3 on the same edge that `level[3]` rises leaves `pend[3]=1`.
- Async reset asserted between clock edges while `cnt=2` and `pend=0x3`: outputs read 0 immediately. After release, with the button still held, `level` rises only after a full 1+4 edges.
